fmul_norm_round: RTL
====================

FMUL_NORM_ROUND -- requirements
Module: fmul_norm_round

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are clk (rising edge) and clrn (active-low clear).
REQ-002 clk  input  1  pipeline clock.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream product and operand info valid.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 prod  input  52  unsigned 26x26 significand product, value in [1,4) with binary point between bits 50 and 49.
REQ-007 exp  input  10  two's-complement biased exponent sum (ea+eb-127).
REQ-008 sign  input  1  result sign (sa^sb).
REQ-009 rm  input  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
REQ-010 in_nan, in_inf, in_zero  input  1 each  special-case flags from the operand decode stage.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 s  output  32  IEEE-754 single-precision result.
REQ-014 overflow, underflow, inexact  output  1 each  exception flags, qualified by out_valid.

Function
REQ-015 The block SHALL be a 2-stage pipeline: S1 normalizes, S2 rounds and packs; latency is 2 cycles from accept to out_valid with out_ready high; throughput is 1 result per cycle.
REQ-016 Advance enable SHALL be en = ~out_valid | out_ready; in_ready = en; both stages move only when en=1; bubbles SHALL propagate as valid=0.
REQ-017 While out_valid=1 and out_ready=0, s, the flags and out_valid SHALL hold stable; no result is dropped or duplicated.
REQ-018 S1: if prod[51]=1 -> frac=prod[50:28], guard=prod[27], sticky=|prod[26:0], e=exp+1; else frac=prod[49:27], guard=prod[26], sticky=|prod[25:0], e=exp.
REQ-019 Round-up SHALL be: RNE guard&(sticky|frac[0]); toward -inf sign&(guard|sticky); toward +inf ~sign&(guard|sticky); toward zero never.
REQ-020 inexact SHALL be guard|sticky for a normal finite result.
REQ-021 Rounding carry-out (frac all ones plus 1) SHALL yield frac=0 and e+1.
REQ-022 Final e>=255: overflow=1, inexact=1; result SHALL be sign-inf for RNE and for the directed mode toward the sign; otherwise max finite {sign,8'hFE,23'h7FFFFF}.
REQ-023 Final e<=0 (10-bit signed compare): flush to signed zero, underflow=1, inexact=1.
REQ-024 Special priority SHALL be in_nan > in_inf > in_zero > normal: NaN -> 32'h7FC00000; inf -> {sign,8'hFF,23'h0}; zero -> {sign,31'h0}; all flags 0 for specials.
REQ-025 Exponent arithmetic SHALL be 10-bit signed throughout; no wrap-around into the 8-bit field before the REQ-022/023 checks.

Reset
REQ-026 On clrn=0, both stage valids, out_valid, s, overflow, underflow and inexact SHALL clear to 0 immediately, regardless of clk.
REQ-027 In-flight items at reset SHALL be discarded; in_ready SHALL be 1 during and after reset.
REQ-028 The first accept after clrn deasserts SHALL produce out_valid exactly 2 cycles later.

Verification
REQ-029 prod=52'hFFFFFF8000001, exp=127, sign=0, rm=00 -> s=32'h40800000, inexact=1, overflow=0, out_valid at cycle 2.
REQ-030 prod=52'h4000000000000, exp=127, sign=1, rm=00 -> s=32'hBF800000, all flags 0.
REQ-031 prod[51]=1 with remaining bits 0, exp=254, sign=0: rm=00 -> s=32'h7F800000, overflow=1; rm=11 -> s=32'h7F7FFFFF, overflow=1.
REQ-032 prod=52'h4000000000000, exp=0, sign=1 -> s=32'h80000000, underflow=1, inexact=1; in_nan=1 with in_inf=1 -> s=32'h7FC00000.
REQ-033 RNE tie: prod=52'h4000004000000 (guard=1, sticky=0, frac[0]=0), exp=127 -> s=32'h3F800000 with no round-up, inexact=1.
REQ-034 Stream 4 back-to-back items, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, s stable, all 4 results emitted in order; assert clrn=0 with 2 items in flight -> out_valid=0 at once, nothing emitted afterwards.

Source files
------------

// File: rtl/fmul_norm_round.sv
// Single-precision multiplier back end: S1 normalizes the 26x26 significand product,
// S2 rounds, handles specials and exponent range, and packs the IEEE-754 result.
module fmul_norm_round (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [51:0] prod,
    input  logic [9:0]  exp,
    input  logic        sign,
    input  logic [1:0]  rm,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RDN = 2'b01,
        RM_RUP = 2'b10,
        RM_RTZ = 2'b11
    } rm_e;

    typedef struct packed {
        logic        sign;
        rm_e         rm;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [22:0] frac;
        logic        guard;
        logic        sticky;
        logic [9:0]  e;
    } s1_t;

    logic en;
    logic v1;
    s1_t  s1_d, s1_q;

    // One shared enable: the whole pipe freezes while the output is stalled.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // NOTE: every variable in a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = sign;
        s1_d.rm   = rm_e'(rm);
        s1_d.nan  = in_nan;
        s1_d.inf  = in_inf;
        s1_d.zero = in_zero;
        if (prod[51]) begin
            s1_d.frac   = prod[50:28];
            s1_d.guard  = prod[27];
            s1_d.sticky = |prod[26:0];
            s1_d.e      = exp + 10'd1;
        end else begin
            s1_d.frac   = prod[49:27];
            s1_d.guard  = prod[26];
            s1_d.sticky = |prod[25:0];
            s1_d.e      = exp;
        end
    end

    logic               round_up;
    logic               to_inf;
    logic [23:0]        frac_sum;
    logic signed [9:0]  e_fin;
    logic [31:0]        s_d;
    logic               ovf_d, unf_d, inx_d;

    always_comb begin
        round_up = 1'b0;
        unique case (s1_q.rm)
            RM_RNE:  round_up = s1_q.guard & (s1_q.sticky | s1_q.frac[0]);
            RM_RDN:  round_up = s1_q.sign & (s1_q.guard | s1_q.sticky);
            RM_RUP:  round_up = ~s1_q.sign & (s1_q.guard | s1_q.sticky);
            default: round_up = 1'b0;
        endcase

        // A carry out of the fraction leaves frac_sum[22:0] all zeros and bumps e.
        frac_sum = {1'b0, s1_q.frac} + 24'(round_up);
        e_fin    = $signed(s1_q.e) + (frac_sum[23] ? 10'sd1 : 10'sd0);
        to_inf   = (s1_q.rm == RM_RNE) | ((s1_q.rm == RM_RDN) & s1_q.sign)
                 | ((s1_q.rm == RM_RUP) & ~s1_q.sign);

        s_d   = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        if (s1_q.nan) begin
            s_d = 32'h7FC0_0000;
        end else if (s1_q.inf) begin
            s_d = {s1_q.sign, 8'hFF, 23'h0};
        end else if (s1_q.zero) begin
            s_d = {s1_q.sign, 31'h0};
        end else if (e_fin >= 10'sd255) begin
            s_d   = to_inf ? {s1_q.sign, 8'hFF, 23'h0} : {s1_q.sign, 8'hFE, 23'h7F_FFFF};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            s_d   = {s1_q.sign, 31'h0};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end else begin
            s_d   = {s1_q.sign, e_fin[7:0], frac_sum[22:0]};
            inx_d = s1_q.guard | s1_q.sticky;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so both stages sample
    // the pre-edge values and shift together.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v1        <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            s1_q      <= s1_d;
            out_valid <= v1;
            s         <= s_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
            inexact   <= inx_d;
        end
    end

endmodule
